miinst_queue: RTL and testbench
===============================

MIINST_QUEUE -- requirements
Module: miinst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count (power of two, >= 4).
REQ-002 SHALL have parameter ENQ_W, default 2, meaning maximum micro-instructions enqueued per cycle.
REQ-003 SHALL have port clk  input  1  clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port enq_num  input  $clog2(ENQ_W+1)  number of valid enqueue slots this cycle (0..ENQ_W).
REQ-006 SHALL have port enq_miinst  input  miinst_t[ENQ_W]  enqueue payload; slot 0 is oldest, slots used contiguously from 0.
REQ-007 SHALL have port enq_ready  output  1  queue accepts ENQ_W entries this cycle.
REQ-008 SHALL have port deq_miinst_head  output  miinst_t  oldest entry, or opcode MIOP_NOP when empty.
REQ-009 SHALL have port deq_valid  output  1  deq_miinst_head holds a real entry.
REQ-010 SHALL have port stall  input  1  decode stage cannot consume head this cycle.
REQ-011 SHALL have port flush  input  1  discard all entries (branch mispredict or exception).
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 SHALL store entries in a circular buffer with read/write pointers of $clog2(DEPTH)+1 bits; index = low bits, wrap modulo DEPTH.
REQ-014 SHALL drive enq_ready = (DEPTH - count) >= ENQ_W, computed from registered count only (no same-cycle dequeue credit).
REQ-015 SHALL write enq_num entries at wptr..wptr+enq_num-1 (mod DEPTH) and advance wptr by enq_num when enq_ready=1 and flush=0.
REQ-016 SHALL ignore enqueue entirely (no write, no pointer change) when enq_ready=0; partial acceptance is forbidden.
REQ-017 SHALL drive deq_valid = (count != 0) and deq_miinst_head combinationally from the entry at rptr; when count=0, head opcode SHALL be MIOP_NOP.
REQ-018 SHALL dequeue (advance rptr by 1) when deq_valid=1, stall=0, flush=0.
REQ-019 SHALL update count next cycle as count + accepted_enq - dequeued; simultaneous enqueue and dequeue SHALL be supported at any occupancy where enq_ready=1.
REQ-020 SHALL, on flush=1, set rptr=wptr, count=0 next cycle; same-cycle enqueue and dequeue are discarded; deq_valid=0 the cycle after.
REQ-021 SHALL present a newly enqueued entry on deq_miinst_head no earlier than the cycle after its enqueue (1-cycle latency, no bypass).
REQ-022 SHALL preserve strict program order across wrap-around: entry i+1 is never dequeued before entry i.
REQ-023 SHALL never exceed count=DEPTH; count=DEPTH implies enq_ready=0 for any ENQ_W>=1.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set rptr=0, wptr=0, count=0; outputs after that edge: deq_valid=0, head opcode MIOP_NOP, enq_ready=1, count=0.
REQ-025 SHALL give rst priority over flush, enqueue and dequeue; storage contents need no reset.
REQ-026 SHALL, on rst asserted mid-operation, discard all entries, and the first cycle after rst deasserts SHALL accept enqueue.

Structure
REQ-027 SHALL take miinst_t and MIOP_NOP from the shared package; a MIQ_DEPTH default constant SHALL be added to the shared package.
REQ-028 SHALL contain one sub-module miinst_queue_mem: DEPTH-entry register array, ENQ_W write ports, one asynchronous read port.
REQ-029 SHALL keep pointer/count logic in miinst_queue itself; no latches, no multi-driven state.

Verification
REQ-030 Reset then enq_num=2 (A,B), stall=0 -> next cycle head=A, deq_valid=1, count=2; following cycle head=B, count=1.
REQ-031 Fill with stall=1, enq_num=2 per cycle -> count 2,4,6,8; enq_ready=0 at count 7 and 8; extra enqueue at count 8 dropped, count stays 8.
REQ-032 Count=6, enq_num=2, stall=0 same cycle -> count=7, enq_ready drops to 0; order preserved.
REQ-033 Wrap: push 20 sequentially tagged entries with random stall/enq_num -> popped tags exactly 0..19 in order, count never >8.
REQ-034 Count=5, flush=1 with enq_num=2 -> next cycle count=0, deq_valid=0, head opcode MIOP_NOP; following enqueue C -> head=C.
REQ-035 rst=1 at count=4 with flush=1 and enq_num=2 -> count=0, enq_ready=1, deq_valid=0; enqueue accepted the cycle rst drops.

Source files
------------

// File: rtl/miinst_queue_pkg.sv
// Shared micro-instruction types for the decode-side instruction queue.
// Holds the payload layout, the NOP encoding and the default queue depth.
package miinst_queue_pkg;

   localparam int MIQ_DEPTH = 8;

   typedef enum logic [3:0] {
      MIOP_NOP    = 4'd0,
      MIOP_ALU    = 4'd1,
      MIOP_LOAD   = 4'd2,
      MIOP_STORE  = 4'd3,
      MIOP_BRANCH = 4'd4
   } miop_e;

   typedef struct packed {
      miop_e       opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [15:0] tag;
   } miinst_t;

   localparam miinst_t MIINST_NOP = '{
      opcode: MIOP_NOP,
      rd:     5'd0,
      rs1:    5'd0,
      rs2:    5'd0,
      tag:    16'd0
   };

endpackage

// File: rtl/miinst_queue_if.sv
// Enqueue/dequeue bundle between the fetch side, the queue and decode.
// The master drives enqueue, stall and flush; the slave is the queue itself.
interface miinst_queue_if
   import miinst_queue_pkg::*;
#(
   parameter int DEPTH = MIQ_DEPTH,
   parameter int ENQ_W = 2
);

   logic [$clog2(ENQ_W+1)-1:0] enq_num;
   miinst_t                    enq_miinst [ENQ_W];
   logic                       enq_ready;
   miinst_t                    deq_miinst_head;
   logic                       deq_valid;
   logic                       stall;
   logic                       flush;
   logic [$clog2(DEPTH):0]     count;

   modport master (
      output enq_num,
      output enq_miinst,
      output stall,
      output flush,
      input  enq_ready,
      input  deq_miinst_head,
      input  deq_valid,
      input  count
   );

   modport slave (
      input  enq_num,
      input  enq_miinst,
      input  stall,
      input  flush,
      output enq_ready,
      output deq_miinst_head,
      output deq_valid,
      output count
   );

endinterface

// File: rtl/miinst_queue_mem.sv
// Storage for the instruction queue: DEPTH registers, ENQ_W write ports,
// one asynchronous read port. Contents are intentionally not reset.
module miinst_queue_mem
   import miinst_queue_pkg::*;
#(
   parameter  int DEPTH = MIQ_DEPTH,
   parameter  int ENQ_W = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [ENQ_W-1:0] we,
   input  logic [AW-1:0]    waddr [ENQ_W],
   input  miinst_t          wdata [ENQ_W],
   input  logic [AW-1:0]    raddr,
   output miinst_t          rdata
);

   miinst_t mem [DEPTH];

   // Write addresses of active ports are always distinct, so port order is irrelevant.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENQ_W; i++) begin
         if (we[i]) begin
            mem[waddr[i]] <= wdata[i];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/miinst_queue.sv
// Circular micro-instruction queue between fetch and decode.
// Accepts up to ENQ_W entries per cycle all-or-nothing; dequeues one per cycle.
module miinst_queue
   import miinst_queue_pkg::*;
#(
   parameter int DEPTH = MIQ_DEPTH,
   parameter int ENQ_W = 2
) (
   input  logic          clk,
   input  logic          rst,
   miinst_queue_if.slave q
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = $clog2(ENQ_W + 1);

   logic [PW-1:0]    rptr;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    count_r;
   logic [31:0]      free_slots;
   logic             enq_ready;
   logic             deq_valid;
   logic             do_enq;
   logic             do_deq;
   logic [PW-1:0]    acc_num;
   logic [ENQ_W-1:0] we;
   logic [AW-1:0]    waddr [ENQ_W];
   miinst_t          rdata;

   // Readiness uses only the registered count, so a same-cycle dequeue never
   // grants extra room; this keeps enq_ready off the stall path.
   always_comb begin
      free_slots = 32'(DEPTH) - 32'(count_r);
      enq_ready  = free_slots >= 32'(ENQ_W);
      deq_valid  = count_r != '0;
      do_enq     = enq_ready && !q.flush && !rst && (q.enq_num != '0);
      do_deq     = deq_valid && !q.stall && !q.flush;
      acc_num    = do_enq ? PW'(q.enq_num) : '0;
   end

   for (genvar i = 0; i < ENQ_W; i++) begin : g_wr
      assign we[i]    = do_enq && (EW'(i) < q.enq_num);
      assign waddr[i] = wptr[AW-1:0] + AW'(i);
   end

   miinst_queue_mem #(
      .DEPTH (DEPTH),
      .ENQ_W (ENQ_W)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (q.enq_miinst),
      .raddr (rptr[AW-1:0]),
      .rdata (rdata)
   );

   // Reset beats flush, and flush discards any enqueue or dequeue in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr    <= '0;
         wptr    <= '0;
         count_r <= '0;
      end else if (q.flush) begin
         rptr    <= wptr;
         count_r <= '0;
      end else begin
         wptr    <= wptr + acc_num;
         rptr    <= rptr + PW'(do_deq);
         count_r <= count_r + acc_num - PW'(do_deq);
      end
   end

   always_comb begin
      q.deq_miinst_head = rdata;
      if (!deq_valid) begin
         q.deq_miinst_head = MIINST_NOP;
      end
   end

   assign q.enq_ready = enq_ready;
   assign q.deq_valid = deq_valid;
   assign q.count     = count_r;

endmodule

// File: tb/tb_miinst_queue.sv
// Scoreboard bench for miinst_queue: the driver pushes accepted entries, the
// negedge monitor pops on every real dequeue and checks occupancy flags.
module tb_miinst_queue;
   import miinst_queue_pkg::*;

   localparam int DEPTH = MIQ_DEPTH;
   localparam int ENQ_W = 2;
   localparam int EW    = $clog2(ENQ_W + 1);

   logic clk = 1'b0;
   logic rst;

   miinst_queue_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W)) bus ();

   miinst_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W)) dut (
      .clk (clk),
      .rst (rst),
      .q   (bus)
   );

   always #5 clk = ~clk;

   miinst_t sb_q[$];
   int      occ      = 0;
   int      next_tag = 0;
   int      total    = 0;
   int      bad      = 0;
   bit      checking = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic miinst_t mkInst(int tag);
      miinst_t m;
      m.opcode = miop_e'(4'($urandom_range(1, 4)));
      m.rd     = 5'($urandom);
      m.rs1    = 5'($urandom);
      m.rs2    = 5'($urandom);
      m.tag    = 16'(tag);
      return m;
   endfunction

   // Model: the queue is a FIFO of whole entries; occupancy is its size.
   task automatic applyStimulus(input logic r, input logic f, input logic s, input int n);
      int  nocc;
      bit  acc;
      rst         = r;
      bus.flush   = f;
      bus.stall   = s;
      bus.enq_num = EW'(n);
      for (int i = 0; i < ENQ_W; i++) begin
         bus.enq_miinst[i] = mkInst(next_tag + i);
      end
      acc = !r && !f && (DEPTH - occ >= ENQ_W) && (n > 0);
      if (r || f) begin
         sb_q.delete();
         nocc = 0;
      end else begin
         nocc = occ;
         if (occ != 0 && !s) nocc--;
         if (acc) begin
            for (int i = 0; i < n; i++) sb_q.push_back(bus.enq_miinst[i]);
            nocc     += n;
            next_tag += n;
         end
      end
      @(posedge clk);
      occ = nocc;
      #1;
   endtask

   task automatic checkOutput();
      miinst_t exp;
      check("count", 64'(bus.count), 64'(occ));
      check("enq_ready", 64'(bus.enq_ready), (DEPTH - occ >= ENQ_W) ? 64'd1 : 64'd0);
      check("deq_valid", 64'(bus.deq_valid), (occ != 0) ? 64'd1 : 64'd0);
      check("count_bound", (int'(bus.count) <= DEPTH) ? 64'd1 : 64'd0, 64'd1);
      if (bus.deq_valid !== 1'b1) begin
         check("head_nop", 64'(bus.deq_miinst_head.opcode), 64'(MIOP_NOP));
      end else if (!bus.stall && !bus.flush && !rst) begin
         if (sb_q.size() == 0) begin
            check("head_pop_empty", 64'(bus.deq_miinst_head), 64'(MIINST_NOP));
         end else begin
            exp = sb_q.pop_front();
            check("head", 64'(bus.deq_miinst_head), 64'(exp));
         end
      end
   endtask

   always @(negedge clk) begin
      if (checking) checkOutput();
   end

   task automatic drain();
      int guard;
      guard = 0;
      while (occ != 0 && guard < 4 * DEPTH) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 0);
         guard++;
      end
      check("drain_sb", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.flush   = 1'b0;
      bus.stall   = 1'b0;
      bus.enq_num = '0;
      for (int i = 0; i < ENQ_W; i++) bus.enq_miinst[i] = MIINST_NOP;

      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      checking = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 0);

      // Two entries, then dequeue them in order.
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      drain();

      // Fill with stall; the fifth pair arrives at count 8 and is dropped.
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2);
      drain();

      // Count 6 plus simultaneous enqueue and dequeue gives 7, then a drop.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      drain();

      // Flush at count 5 with a same-cycle enqueue, then a fresh entry C.
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 0);
      drain();

      // Reset at count 4 alongside flush and enqueue; enqueue right after.
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      applyStimulus(1'b1, 1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 2);
      drain();

      // Random traffic with wrap-around, stalls and occasional flush/reset.
      for (int c = 0; c < 400; c++) begin
         applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                       int'($urandom_range(0, ENQ_W)));
      end
      drain();

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
